sample_iterator: RTL and testbench

- Bounding-box sample generator; the producer side of the sample/triangle interface that the sample-test stage consumes.
- Accepts one triangle with its precomputed, grid-snapped bounding box from the bbox stage (R13).
- Walks every sample location inside the box in raster order, one per cycle, emitting triangle, color, sample and a valid flag (R14).
- Stalls upstream with an active-low halt while iterating, and freezes on downstream halt.

---
 rtl/sample_iterator.sv | 182 ++++++++++++++++++
 tb/tb_sample_iterator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_iterator.sv
// sample_iterator: bounding-box sample generator.
// Accepts one triangle plus its grid-snapped bounding box. It then walks every
// sample position inside the box in raster order (x fastest), one per cycle.
// Optional feature macro: SAMPLE_JITTER_EN adds an LFSR-based sub-step jitter
// to sample_R14S. sampleGrid_R14S always carries the exact grid position.
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                          validTri_R13H,
  input  logic        [3:0]                             subSample_RnnnnU,
  input  logic                                          halt_RnnnnL,
  output logic                                          haltUp_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
  output logic signed [1:0][SIGFIG-1:0]                 sampleGrid_R14S,
  output logic                                          validSamp_R14H
);

  typedef enum logic [0:0] {ST_WAIT = 1'b0, ST_TEST = 1'b1} state_t;

  localparam logic [SIGFIG-1:0] ONE = {{(SIGFIG-1){1'b0}}, 1'b1};

  // One-hot spacing to step size; anything not one-hot means a 1-pixel step.
  function automatic logic [SIGFIG-1:0] f_step(input logic [3:0] ss);
    logic [SIGFIG-1:0] s;
    case (ss)
      4'b1000: s = ONE << RADIX;
      4'b0100: s = ONE << (RADIX - 1);
      4'b0010: s = ONE << (RADIX - 2);
      4'b0001: s = ONE << (RADIX - 3);
      default: s = ONE << RADIX;
    endcase
    return s;
  endfunction

  state_t                                        r_state;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
  logic        [COLORS-1:0][SIGFIG-1:0]          r_color;
  logic signed [SIGFIG-1:0] r_ll_x, r_ll_y, r_ur_x, r_ur_y;
  logic signed [SIGFIG-1:0] r_grid_x, r_grid_y, r_samp_x, r_samp_y;
  logic        [SIGFIG-1:0] r_step;
  logic                     r_valid;

  logic        [SIGFIG-1:0] w_acc_step;
  logic signed [SIGFIG:0]   w_x_inc, w_y_inc;
  logic                     w_x_fits, w_y_fits, w_box_ok, w_last;
  logic signed [SIGFIG-1:0] w_nxt_x, w_nxt_y;
  logic        [SIGFIG-1:0] w_acc_off_x, w_acc_off_y, w_run_off_x, w_run_off_y;

  assign w_acc_step = f_step(subSample_RnnnnU);

  // Increments are formed one bit wider so x+step near the top of range cannot wrap.
  assign w_x_inc  = $signed({r_grid_x[SIGFIG-1], r_grid_x}) + $signed({1'b0, r_step});
  assign w_y_inc  = $signed({r_grid_y[SIGFIG-1], r_grid_y}) + $signed({1'b0, r_step});
  assign w_x_fits = (w_x_inc <= $signed({r_ur_x[SIGFIG-1], r_ur_x}));
  assign w_y_fits = (w_y_inc <= $signed({r_ur_y[SIGFIG-1], r_ur_y}));
  assign w_box_ok = ($signed(box_R13S[0][0]) <= $signed(box_R13S[1][0])) &&
                    ($signed(box_R13S[0][1]) <= $signed(box_R13S[1][1]));

  // Next raster position: step x, else wrap to ll.x and step y, else flag last sample.
  always_comb begin
    w_nxt_x = r_grid_x;
    w_nxt_y = r_grid_y;
    w_last  = 1'b0;
    if (w_x_fits) begin
      w_nxt_x = w_x_inc[SIGFIG-1:0];
    end else if (w_y_fits) begin
      w_nxt_x = r_ll_x;
      w_nxt_y = w_y_inc[SIGFIG-1:0];
    end else begin
      w_last = 1'b1;
    end
  end

`ifdef SAMPLE_JITTER_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] f_lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign w_lfsr_nxt  = f_lfsr_next(r_lfsr);
  // Offsets are masked to step-1 so a jittered sample never reaches the next grid point.
  assign w_acc_off_x = {{(SIGFIG-8){1'b0}}, r_lfsr[7:0]}      & (w_acc_step - ONE);
  assign w_acc_off_y = {{(SIGFIG-8){1'b0}}, r_lfsr[15:8]}     & (w_acc_step - ONE);
  assign w_run_off_x = {{(SIGFIG-8){1'b0}}, w_lfsr_nxt[7:0]}  & (r_step - ONE);
  assign w_run_off_y = {{(SIGFIG-8){1'b0}}, w_lfsr_nxt[15:8]} & (r_step - ONE);

  // Advance the jitter source once per consumed sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 16'hACE1;
    end else if (halt_RnnnnL && (r_state == ST_TEST)) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end
`else
  assign w_acc_off_x = {SIGFIG{1'b0}};
  assign w_acc_off_y = {SIGFIG{1'b0}};
  assign w_run_off_x = {SIGFIG{1'b0}};
  assign w_run_off_y = {SIGFIG{1'b0}};
`endif

  // Iterator FSM: accept a triangle in WAIT, emit one sample per un-halted cycle in TEST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_WAIT;
      r_valid  <= 1'b0;
      r_tri    <= '0;
      r_color  <= '0;
      r_ll_x   <= '0;
      r_ll_y   <= '0;
      r_ur_x   <= '0;
      r_ur_y   <= '0;
      r_step   <= '0;
      r_grid_x <= '0;
      r_grid_y <= '0;
      r_samp_x <= '0;
      r_samp_y <= '0;
    end else if (halt_RnnnnL) begin
      case (r_state)
        ST_WAIT: begin
          r_valid <= 1'b0;
          if (validTri_R13H) begin
            r_tri    <= tri_R13S;
            r_color  <= color_R13U;
            r_ll_x   <= box_R13S[0][0];
            r_ll_y   <= box_R13S[0][1];
            r_ur_x   <= box_R13S[1][0];
            r_ur_y   <= box_R13S[1][1];
            r_step   <= w_acc_step;
            r_grid_x <= box_R13S[0][0];
            r_grid_y <= box_R13S[0][1];
            r_samp_x <= box_R13S[0][0] + w_acc_off_x;
            r_samp_y <= box_R13S[0][1] + w_acc_off_y;
            if (w_box_ok) begin
              r_state <= ST_TEST;
              r_valid <= 1'b1;
            end
          end
        end
        ST_TEST: begin
          if (w_last) begin
            r_state <= ST_WAIT;
            r_valid <= 1'b0;
          end else begin
            r_grid_x <= w_nxt_x;
            r_grid_y <= w_nxt_y;
            r_samp_x <= w_nxt_x + w_run_off_x;
            r_samp_y <= w_nxt_y + w_run_off_y;
          end
        end
        default: begin
          r_state <= ST_WAIT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign haltUp_RnnnnL      = (r_state == ST_WAIT) && halt_RnnnnL;
  assign tri_R14S           = r_tri;
  assign color_R14U         = r_color;
  assign sampleGrid_R14S[0] = r_grid_x;
  assign sampleGrid_R14S[1] = r_grid_y;
  assign sample_R14S[0]     = r_samp_x;
  assign sample_R14S[1]     = r_samp_y;
  assign validSamp_R14H     = r_valid;

endmodule

// File: tb/tb_sample_iterator.sv
// Self-checking bench for sample_iterator: expected samples are queued when a
// triangle is accepted and compared as the DUT hands each sample downstream.
module tb_sample_iterator;
  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic clk = 1'b0;
  logic rst;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in, tri_out;
  logic        [COLORS-1:0][SIGFIG-1:0]          col_in, col_out;
  logic signed [1:0][1:0][SIGFIG-1:0]            box_in;
  logic signed [1:0][SIGFIG-1:0]                 samp, grid;
  logic        validTri, halt, haltUp, validSamp;
  logic [3:0]  subSample;

  sample_iterator dut (
    .clk(clk), .rst(rst),
    .tri_R13S(tri_in), .color_R13U(col_in), .box_R13S(box_in),
    .validTri_R13H(validTri), .subSample_RnnnnU(subSample),
    .halt_RnnnnL(halt), .haltUp_RnnnnL(haltUp),
    .tri_R14S(tri_out), .color_R14U(col_out),
    .sample_R14S(samp), .sampleGrid_R14S(grid), .validSamp_R14H(validSamp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int step;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_v;
    logic [COLORS-1:0][SIGFIG-1:0]          col_v;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   first_samp = 1'b1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: a sample shown with halt high is consumed at the next edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    int dx, dy;
    if (rst && validSamp && halt) begin
      if (q.size() == 0) begin
        check_val("unexpected_sample", 64'd1, 64'd0);
      end else begin
        e  = q.pop_front();
        dx = int'($signed(samp[0])) - int'($signed(grid[0]));
        dy = int'($signed(samp[1])) - int'($signed(grid[1]));
        check_val("grid_x", 64'(int'($signed(grid[0]))), 64'(e.x));
        check_val("grid_y", 64'(int'($signed(grid[1]))), 64'(e.y));
        check_val("tri_latched", 64'(tri_out == e.tri_v), 64'd1);
        check_val("color_latched", 64'(col_out == e.col_v), 64'd1);
        check_val("haltup_busy", 64'(haltUp), 64'd0);
`ifdef SAMPLE_JITTER_EN
        check_val("jit_x_range", 64'(dx >= 0 && dx < e.step), 64'd1);
        check_val("jit_y_range", 64'(dy >= 0 && dy < e.step), 64'd1);
        if (first_samp) begin
          check_val("jit_seed_x", 64'(dx), 64'(8'hE1 & (e.step - 1)));
          check_val("jit_seed_y", 64'(dy), 64'(8'hAC & (e.step - 1)));
        end
`else
        check_val("jit_x_zero", 64'(dx), 64'd0);
        check_val("jit_y_zero", 64'(dy), 64'd0);
`endif
        first_samp = 1'b0;
      end
    end
  end

  // Present a triangle, wait for acceptance, queue its expected samples.
  task automatic send_tri(input int llx, input int lly, input int urx, input int ury,
                          input logic [3:0] ss, input int id, output time t_acc);
    int  step;
    bit  acc;
    exp_t e;
    @(posedge clk); #1;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) tri_in[v][a] = 24'(id * 100 + v * 10 + a);
    for (int c = 0; c < COLORS; c++) col_in[c] = 24'(id * 7 + c + 1);
    box_in[0][0] = 24'(llx); box_in[0][1] = 24'(lly);
    box_in[1][0] = 24'(urx); box_in[1][1] = 24'(ury);
    subSample = ss;
    validTri  = 1'b1;
    case (ss)
      4'b0100: step = 512;
      4'b0010: step = 256;
      4'b0001: step = 128;
      default: step = 1024;
    endcase
    acc = 1'b0;
    t_acc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (haltUp) begin acc = 1'b1; t_acc = $time; break; end
    end
    if (!acc) begin
      check_val("accept_timeout", 64'd0, 64'd1);
    end else begin
      e.step = step; e.tri_v = tri_in; e.col_v = col_in;
      for (int y = lly; y <= ury; y += step)
        for (int x = llx; x <= urx; x += step) begin
          e.x = x; e.y = y; q.push_back(e);
        end
    end
    @(posedge clk); #1;
    validTri = 1'b0;
    tri_in   = ~tri_in;
    col_in   = ~col_in;
  endtask

  // Wait (bounded) until every queued sample is consumed and the block is idle.
  task automatic wait_drain(input string tag);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0 && haltUp && !validSamp) break;
    end
    check_val({tag, "_drain"}, 64'(q.size()), 64'd0);
    check_val({tag, "_idle_valid"}, 64'(validSamp), 64'd0);
    check_val({tag, "_idle_haltup"}, 64'(haltUp), 64'd1);
  endtask

  initial begin
    time t1, t2;
    rst = 1'b0; validTri = 1'b0; halt = 1'b1; subSample = 4'b1000;
    tri_in = '0; col_in = '0; box_in = '0;
    #12;
    check_val("rst_valid", 64'(validSamp), 64'd0);
    check_val("rst_haltup", 64'(haltUp), 64'd1);
    check_val("rst_grid", 64'(grid), 64'd0);
    check_val("rst_sample", 64'(samp), 64'd0);
    check_val("rst_tri", 64'(tri_out == '0), 64'd1);
    @(negedge clk); rst = 1'b1;

    // 2x3 box at 1-pixel spacing, back-to-back valid samples
    send_tri(0, 0, 2048, 1024, 4'b1000, 1, t1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("s1_consecutive_valid", 64'(validSamp), 64'd1);
    end
    @(negedge clk);
    check_val("s1_end_valid", 64'(validSamp), 64'd0);
    check_val("s1_end_haltup", 64'(haltUp), 64'd1);
    check_val("s1_all_seen", 64'(q.size()), 64'd0);

    // single-point box followed immediately by another triangle
    send_tri(3072, 5120, 3072, 5120, 4'b1000, 2, t1);
    send_tri(0, 0, 0, 0, 4'b1000, 3, t2);
    check_val("s2_accept_gap", 64'((t2 - t1) >= 20), 64'd1);
    wait_drain("s2");

    // empty box: nothing emitted
    send_tri(1024, 0, 0, 0, 4'b1000, 4, t1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("s3_no_valid", 64'(validSamp), 64'd0);
      check_val("s3_haltup", 64'(haltUp), 64'd1);
    end

    // half-pixel spacing with a downstream halt on the second sample
    send_tri(0, 0, 1024, 0, 4'b0100, 5, t1);
    @(posedge clk); #1;
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("s4_hold_valid", 64'(validSamp), 64'd1);
      check_val("s4_hold_x", 64'(int'($signed(grid[0]))), 64'd512);
    end
    @(posedge clk); #1;
    halt = 1'b1;
    wait_drain("s4");

    // near top of signed range: x+step must not wrap into a second sample
    send_tri(8387584, 0, 8388607, 0, 4'b1000, 6, t1);
    wait_drain("s5");

    // signed box with random downstream halts at quarter-pixel spacing
    send_tri(-512, -256, 256, 256, 4'b0010, 7, t1);
    for (int k = 0; k < 200 && q.size() != 0; k++) begin
      @(posedge clk); #1;
      halt = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    halt = 1'b1;
    wait_drain("s6");

    // reset during the third sample aborts the triangle
    send_tri(0, 0, 2048, 1024, 4'b1000, 8, t1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_val("s7_rst_valid", 64'(validSamp), 64'd0);
    check_val("s7_rst_haltup", 64'(haltUp), 64'd1);
    check_val("s7_rst_grid", 64'(grid), 64'd0);
    check_val("s7_rst_sample", 64'(samp), 64'd0);
    check_val("s7_rst_tri", 64'(tri_out == '0), 64'd1);
    check_val("s7_rst_color", 64'(col_out == '0), 64'd1);
    q.delete();
    @(negedge clk); #1;
    rst = 1'b1;
    send_tri(4096, 2048, 5120, 2048, 4'b1000, 9, t1);
    wait_drain("s7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
